// File: rtl/out_capture_uart.sv
// Captures changes on an observed byte bus into a 4-entry FIFO and streams each captured
// byte out as an 8N1 UART frame.
module out_capture_uart #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] data_in,
    output logic       tx,
    output logic       busy,
    output logic [2:0] fifo_count,
    output logic       overflow
);

    localparam int unsigned CntW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]      Depth  = 3'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic [7:0]      last_q, last_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [2:0]      count_q, count_d;
    logic            ovf_q, ovf_d;
    logic            push, pop, wr_en, bit_done;

    // FIFO bookkeeping; pop is decided from pre-edge occupancy so a full FIFO can still accept
    // a push on the same edge the transmitter drains it.
    always_comb begin
        push     = ena && (data_in != last_q);
        bit_done = (cnt_q == CntMax);
        pop      = (count_q != 3'd0) &&
                   ((state_q == StIdle) || ((state_q == StStop) && bit_done));
        wr_en    = push && ((count_q != Depth) || pop);
        last_d   = push ? data_in : last_q;
        wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + {2'b00, wr_en} - {2'b00, pop};
        ovf_d    = ovf_q | (push & ~wr_en);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                tx_d  = 1'b1;
                if (pop) begin
                    state_d = StStart;
                    shift_d = mem_q[rd_ptr_q];
                    tx_d    = 1'b0;
                end
            end
            StStart: begin
                if (bit_done) begin
                    cnt_d     = '0;
                    state_d   = StData;
                    bit_idx_d = 3'd0;
                    tx_d      = shift_q[0];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (bit_done) begin
                    cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[bit_idx_q + 3'd1];
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (bit_done) begin
                    cnt_d = '0;
                    // Chain straight into the next start bit so queued frames have no gap.
                    if (pop) begin
                        state_d = StStart;
                        shift_d = mem_q[rd_ptr_q];
                        tx_d    = 1'b0;
                    end else begin
                        state_d = StIdle;
                        tx_d    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                tx_d    = 1'b1;
            end
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            last_q    <= 8'h00;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= 3'd0;
            ovf_q     <= 1'b0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= 8'h00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            last_q    <= last_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            if (wr_en) mem_q[wr_ptr_q] <= data_in;
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign fifo_count = count_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_out_capture_uart.sv
// Bench for out_capture_uart: frame-level queue model checked every cycle, plus directed
// scenarios with literal expectations.
module tb_out_capture_uart;

    localparam int Cpb      = 4;
    localparam int FrameLen = 10 * Cpb;

    logic       clk = 1'b0;
    logic       clk_en = 1'b0;
    logic       rst;
    logic       ena;
    logic [7:0] data_in;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_count;
    logic       overflow;

    int n_vec = 0;
    int n_err = 0;

    out_capture_uart #(
        .CLKS_PER_BIT(Cpb),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .data_in   (data_in),
        .tx        (tx),
        .busy      (busy),
        .fifo_count(fifo_count),
        .overflow  (overflow)
    );

    always #5 if (clk_en) clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Frame-level model: a byte queue plus the position inside the frame being sent.
    logic [7:0] m_q[$];
    logic [7:0] m_cur  = 8'h00;
    logic [7:0] m_last = 8'h00;
    bit         m_active = 1'b0;
    int         m_pos = 0;
    bit         m_ovf = 1'b0;

    function automatic logic model_tx();
        int b;
        if (!m_active) return 1'b1;
        b = m_pos / Cpb;
        if (b == 0) return 1'b0;
        if (b <= 8) return m_cur[b-1];
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_active = 1'b0;
            m_pos    = 0;
            m_last   = 8'h00;
            m_ovf    = 1'b0;
        end else begin
            bit         fin, pop, push;
            logic [7:0] d;
            d    = data_in;
            fin  = m_active && (m_pos == FrameLen - 1);
            pop  = (!m_active || fin) && (m_q.size() > 0);
            push = ena && (d != m_last);
            if (push) m_last = d;
            if (pop) begin
                m_cur    = m_q.pop_front();
                m_active = 1'b1;
                m_pos    = 0;
            end else if (fin) begin
                m_active = 1'b0;
            end else if (m_active) begin
                m_pos++;
            end
            if (push) begin
                if (m_q.size() < 4) m_q.push_back(d);
                else m_ovf = 1'b1;
            end
        end
        #1;
        chk("cyc_tx", 32'(tx), 32'(model_tx()));
        chk("cyc_busy", 32'(busy), 32'(m_active));
        chk("cyc_fifo_count", 32'(fifo_count), 32'(m_q.size()));
        chk("cyc_overflow", 32'(overflow), 32'(m_ovf));
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    int exp_a5[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

    initial begin
        int busy_cnt;
        rst     = 1'b1;
        ena     = 1'b1;
        data_in = 8'h5A;
        #3;
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fifo_count", 32'(fifo_count), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        data_in = 8'hC3;
        ena     = 1'b0;
        #3;
        chk("rst_hold_tx", 32'(tx), 32'd1);
        chk("rst_hold_busy", 32'(busy), 32'd0);

        clk_en = 1'b1;
        tick(2);
        data_in = 8'h00;
        ena     = 1'b1;
        rst     = 1'b0;
        tick(5);
        chk("post_rst_idle_busy", 32'(busy), 32'd0);
        chk("post_rst_idle_fifo", 32'(fifo_count), 32'd0);

        // Single 0xA5 frame, bit-by-bit against a hand-listed waveform.
        data_in = 8'hA5;
        tick(1);
        chk("a5_queued", 32'(fifo_count), 32'd1);
        chk("a5_not_yet_busy", 32'(busy), 32'd0);
        tick(1);
        for (int i = 0; i < FrameLen; i++) begin
            chk("a5_tx_bit", 32'(tx), 32'(exp_a5[i / Cpb]));
            chk("a5_busy", 32'(busy), 32'd1);
            tick(1);
        end
        chk("a5_end_busy", 32'(busy), 32'd0);
        chk("a5_end_tx", 32'(tx), 32'd1);

        // Held value produces exactly one frame.
        data_in  = 8'h3C;
        busy_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            if (busy) busy_cnt++;
        end
        chk("norepeat_busy_cycles", 32'(busy_cnt), 32'd40);
        chk("norepeat_tx", 32'(tx), 32'd1);
        chk("norepeat_busy", 32'(busy), 32'd0);

        // Six pushes on consecutive edges: five fit, the sixth is dropped.
        for (int i = 0; i < 6; i++) begin
            data_in = 8'(i + 1);
            tick(1);
            if (i == 4) chk("ovf_before_sixth", 32'(overflow), 32'd0);
        end
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_fifo_full", 32'(fifo_count), 32'd4);
        tick(195);
        chk("ovf_last_frame_busy", 32'(busy), 32'd1);
        tick(1);
        chk("ovf_done_busy", 32'(busy), 32'd0);
        chk("ovf_done_fifo", 32'(fifo_count), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // Enable gating.
        ena      = 1'b0;
        data_in  = 8'h11;
        busy_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (busy || fifo_count != 3'd0) busy_cnt++;
        end
        chk("gate_no_activity", 32'(busy_cnt), 32'd0);
        ena = 1'b1;
        tick(1);
        chk("gate_push", 32'(fifo_count), 32'd1);
        busy_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            if (busy) busy_cnt++;
        end
        chk("gate_one_frame", 32'(busy_cnt), 32'd40);

        // Mid-frame reset with a byte queued behind the frame.
        data_in = 8'hFF;
        tick(1);
        data_in = 8'h22;
        tick(1);
        tick(10);
        chk("midrst_in_frame", 32'(busy), 32'd1);
        chk("midrst_queued", 32'(fifo_count), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_tx", 32'(tx), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_fifo", 32'(fifo_count), 32'd0);
        chk("midrst_ovf_cleared", 32'(overflow), 32'd0);
        data_in = 8'h00;
        tick(2);
        rst      = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            tick(1);
            if (busy || fifo_count != 3'd0) busy_cnt++;
        end
        chk("midrst_no_frame", 32'(busy_cnt), 32'd0);
        data_in = 8'h33;
        tick(2);
        chk("midrst_new_frame_busy", 32'(busy), 32'd1);
        chk("midrst_new_frame_start", 32'(tx), 32'd0);
        tick(45);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/out_capture_uart.md
OUT_CAPTURE_UART -- requirements
Module: out_capture_uart

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clock cycles per UART bit; legal values >= 2.
REQ-002 Parameter FIFO_DEPTH, default 4, number of capture FIFO entries; fixed at 4 for this revision.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 ena  input  1  capture enable; 1 = sample data_in each cycle.
REQ-006 data_in  input  8  observed byte, connected to the downstream tt_um_experiment_number_six uo_out bus.
REQ-007 tx  output  1  UART serial output, 8N1, idle high, registered.
REQ-008 busy  output  1  high while a frame is in progress.
REQ-009 fifo_count  output  3  number of bytes currently queued, 0..4.
REQ-010 overflow  output  1  sticky flag; a byte was dropped because the FIFO was full.

Function
REQ-011 The block shall hold register last_sample (8 bits, reset 0x00).
REQ-012 On each rising edge with ena=1 and data_in != last_sample, the block shall push data_in into the FIFO and load last_sample with data_in.
REQ-013 With ena=0, the block shall neither push nor update last_sample; frames already queued or in flight shall still complete.
REQ-014 The FIFO shall be 4 entries, first-in first-out, with a wrap-around read pointer and a wrap-around write pointer.
REQ-015 A push while fifo_count=4 and no pop in the same cycle shall be dropped and shall set overflow=1; overflow shall clear only on reset.
REQ-016 A simultaneous push and pop shall both take effect and leave fifo_count unchanged, including when fifo_count=4.
REQ-017 The TX FSM shall have the states IDLE, START, DATA and STOP; busy shall be 1 in every state except IDLE.
REQ-018 In IDLE, the FSM shall move to START on the next edge if fifo_count>0, popping the head entry into a shift register on that same edge.
REQ-019 In START, tx shall be 0 for CLKS_PER_BIT cycles, then the FSM shall move to DATA.
REQ-020 In DATA, tx shall carry bits 0..7, LSB first, each held for CLKS_PER_BIT cycles, using a 3-bit bit index.
REQ-021 After bit 7, the FSM shall move to STOP.
REQ-022 In STOP, tx shall be 1 for CLKS_PER_BIT cycles.
REQ-023 On the last STOP cycle, the FSM shall move to START (popping the next entry) if fifo_count>0, otherwise to IDLE; back-to-back frames shall have no idle gap.
REQ-024 A frame shall last exactly 10*CLKS_PER_BIT cycles.
REQ-025 Latency: if data_in changes before edge N, the byte shall be written at edge N and tx shall go low after edge N+1 when the FSM was idle.
REQ-026 The baud counter shall count from 0 to CLKS_PER_BIT-1, wrap to 0 and then advance the bit or state; its width shall be sized to fit the parameter.
REQ-027 fifo_count shall reflect the post-edge occupancy.

Reset
REQ-028 While rst=1, asynchronously: tx=1, busy=0, FSM=IDLE, fifo_count=0, FIFO pointers=0, overflow=0, last_sample=0x00, baud counter=0.
REQ-029 Reset asserted mid-frame shall abort the frame immediately and discard all queued bytes.
REQ-030 After rst deasserts, no frame shall start until a qualifying change per REQ-012 occurs.

Verification (CLKS_PER_BIT=4)
REQ-031 Reset check: rst=1 with any inputs -> tx=1, busy=0, fifo_count=0, overflow=0, all holding without clock edges.
REQ-032 Single frame: ena=1, data_in 0x00->0xA5 -> tx low for 4 cycles, then 1,0,1,0,0,1,0,1 each for 4 cycles, then high for 4 cycles; busy high for exactly 40 cycles.
REQ-033 No repeat: data_in held at 0x3C for 200 cycles after the change -> exactly one frame, 0x3C; then tx=1 and busy=0.
REQ-034 Overflow: values 0x01..0x06 on six consecutive edges, FSM idle -> frames 0x01..0x05 back-to-back (200 cycles); 0x06 never sent; overflow=1 from the sixth edge.
REQ-035 Enable gating: ena=0, data_in 0x00->0x11 -> no frame for 100 cycles; then ena=1 with data_in still 0x11 -> one 0x11 frame.
REQ-036 Mid-frame reset: pulse rst during DATA of a 0xFF frame with 0x22 queued -> tx=1 and fifo_count=0 within the reset pulse; 0x22 is never sent; next frame only after data_in changes from 0x00.
